adc_avg: RTL

ADC_AVG -- requirements
Module: adc_avg

---
 rtl/adc_avg.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/adc_avg.sv
// Two-channel ADC window averager: sums 2^LOG2_N samples per channel and emits the floored mean.
// Optional per-window min/max outputs are built when ADC_AVG_PEAK_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; counter at 0, busy low
// ACC   | window in progress (or rearmed back-to-back in continuous mode)
module adc_avg #(
    parameter int LOG2_N = 4
) (
    input  logic        adc_clk,
    input  logic        adc_rstn,
    input  logic [11:0] a_data,
    input  logic [11:0] b_data,
    input  logic        start,
    input  logic        cont,
    output logic        busy,
    output logic        avg_valid,
    output logic [11:0] a_avg,
    output logic [11:0] b_avg
`ifdef ADC_AVG_PEAK_EN
    ,
    output logic [11:0] a_max,
    output logic [11:0] a_min,
    output logic [11:0] b_max,
    output logic [11:0] b_min
`endif
);

    localparam int AW = 12 + LOG2_N;
    localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_N) - 1);

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic signed [AW-1:0] a_acc;
    logic signed [AW-1:0] b_acc;
    logic signed [AW-1:0] a_ext;
    logic signed [AW-1:0] b_ext;
    logic signed [AW-1:0] a_sum;
    logic signed [AW-1:0] b_sum;
    logic signed [11:0]   a_mean;
    logic signed [11:0]   b_mean;
    logic                 take;
    logic                 first;
    logic                 last;
    logic                 rearm;

    // The counter sits at 0 in IDLE, so the start edge is naturally the first sample.
    assign take  = (state == ACC) || start;
    assign first = (cnt == '0);
    assign last  = (cnt == CNT_LAST);

    // For N=1 an IDLE start is its own window end; a held start is simply re-seen from IDLE.
    assign rearm = cont || (start && (state == ACC));

    assign a_ext  = AW'($signed(a_data));
    assign b_ext  = AW'($signed(b_data));
    assign a_sum  = first ? a_ext : a_acc + a_ext;
    assign b_sum  = first ? b_ext : b_acc + b_ext;
    assign a_mean = 12'(a_sum >>> LOG2_N);
    assign b_mean = 12'(b_sum >>> LOG2_N);

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            a_acc     <= '0;
            b_acc     <= '0;
            busy      <= 1'b0;
            avg_valid <= 1'b0;
            a_avg     <= '0;
            b_avg     <= '0;
        end else begin
            avg_valid <= 1'b0;
            if (take) begin
                if (last) begin
                    a_avg     <= a_mean;
                    b_avg     <= b_mean;
                    avg_valid <= 1'b1;
                    cnt       <= '0;
                    state     <= rearm ? ACC : IDLE;
                    busy      <= rearm;
                end else begin
                    a_acc <= a_sum;
                    b_acc <= b_sum;
                    cnt   <= cnt + CW'(1);
                    state <= ACC;
                    busy  <= 1'b1;
                end
            end
        end
    end

`ifdef ADC_AVG_PEAK_EN
    logic signed [11:0] a_hi;
    logic signed [11:0] a_lo;
    logic signed [11:0] b_hi;
    logic signed [11:0] b_lo;
    logic signed [11:0] a_hi_n;
    logic signed [11:0] a_lo_n;
    logic signed [11:0] b_hi_n;
    logic signed [11:0] b_lo_n;
    logic signed [11:0] a_s;
    logic signed [11:0] b_s;

    assign a_s    = $signed(a_data);
    assign b_s    = $signed(b_data);
    assign a_hi_n = (first || (a_s > a_hi)) ? a_s : a_hi;
    assign a_lo_n = (first || (a_s < a_lo)) ? a_s : a_lo;
    assign b_hi_n = (first || (b_s > b_hi)) ? b_s : b_hi;
    assign b_lo_n = (first || (b_s < b_lo)) ? b_s : b_lo;

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            a_hi  <= '0;
            a_lo  <= '0;
            b_hi  <= '0;
            b_lo  <= '0;
            a_max <= '0;
            a_min <= '0;
            b_max <= '0;
            b_min <= '0;
        end else if (take) begin
            a_hi <= a_hi_n;
            a_lo <= a_lo_n;
            b_hi <= b_hi_n;
            b_lo <= b_lo_n;
            if (last) begin
                a_max <= a_hi_n;
                a_min <= a_lo_n;
                b_max <= b_hi_n;
                b_min <= b_lo_n;
            end
        end
    end
`endif

endmodule
